// File: rtl/subneg_core_p.sv
// SUBNEG one-instruction core: mem[B] <= mem[B] - mem[A], branch to C on a
// configurable condition. Drives an external latched-address SRAM bus.
module subneg_core_p #(
  parameter int W       = 8,
  parameter int BR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         ext_latch,
  input  logic         ext_we_n,
  input  logic         step_mode,
  input  logic         step,
  input  logic [W-1:0] in_port,
  input  logic [W-1:0] bus_in,
  output logic [W-1:0] bus_out,
  output logic         bus_oe,
  output logic         mem_latch,
  output logic         mem_oe_n,
  output logic         mem_we_n,
  output logic [W-1:0] out_port,
  output logic         out_strobe,
  output logic [W-1:0] pc,
  output logic         halted,
  output logic [3:0]   state_dbg
);
  typedef enum logic [2:0] {
    S_FETCH_A = 3'd0,
    S_FETCH_B = 3'd1,
    S_FETCH_C = 3'd2,
    S_READ_A  = 3'd3,
    S_READ_B  = 3'd4,
    S_WRITE   = 3'd5,
    S_IDLE    = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [W-1:0] ONES  = {W{1'b1}};
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TWO   = W'(2);
  localparam logic [W-1:0] THREE = W'(3);

  state_t       state_q, state_d;
  logic [2:0]   ph_q, ph_d;
  logic         act_q;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] a_q, b_q, c_q, va_q, vb_q, out_q;
  logic [W-1:0] addr, rd_val, result;
  logic         is_read, is_write, go, taken, out_addr;
  logic         latch_int, oe_int, we_int;

  assign is_read  = (state_q == S_FETCH_A) || (state_q == S_FETCH_B) ||
                    (state_q == S_FETCH_C) || (state_q == S_READ_A) ||
                    (state_q == S_READ_B);
  assign is_write = (state_q == S_WRITE);
  // act_q is low only for the reset cycle, so the first fetch starts on the
  // first edge after rst_n rises.
  assign go       = run & act_q;
  assign out_addr = (b_q == ONES);
  assign result   = vb_q - va_q;

  always_comb begin
    addr = pc_q;
    case (state_q)
      S_FETCH_A: addr = pc_q;
      S_FETCH_B: addr = pc_q + ONE;
      S_FETCH_C: addr = pc_q + TWO;
      S_READ_A:  addr = a_q;
      default:   addr = b_q;
    endcase
  end

  assign rd_val = (addr == ONES) ? in_port : bus_in;

  always_comb begin
    taken = 1'b0;
    if (BR_MODE == 0)      taken = (va_q > vb_q);
    else if (BR_MODE == 1) taken = result[W-1];
    else                   taken = result[W-1] || (result == '0);
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    pc_d    = pc_q;
    if (go) begin
      case (state_q)
        S_FETCH_A, S_FETCH_B, S_FETCH_C, S_READ_A, S_READ_B: begin
          if (ph_q == 3'd3) begin
            ph_d = 3'd0;
            case (state_q)
              S_FETCH_A: state_d = S_FETCH_B;
              S_FETCH_B: state_d = S_FETCH_C;
              S_FETCH_C: state_d = S_READ_A;
              S_READ_A:  state_d = S_READ_B;
              default:   state_d = S_WRITE;
            endcase
          end else begin
            ph_d = ph_q + 3'd1;
          end
        end
        S_WRITE: begin
          if (ph_q == 3'd4) begin
            ph_d = 3'd0;
            pc_d = taken ? c_q : (pc_q + THREE);
            if (taken && (c_q == pc_q)) state_d = S_HALT;
            else if (step_mode)         state_d = S_IDLE;
            else                        state_d = S_FETCH_A;
          end else begin
            ph_d = ph_q + 3'd1;
          end
        end
        S_IDLE: if (step) state_d = S_FETCH_A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH_A;
      ph_q    <= 3'd0;
      act_q   <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      out_q   <= '0;
    end else begin
      act_q   <= 1'b1;
      state_q <= state_d;
      ph_q    <= ph_d;
      pc_q    <= pc_d;
      if (go && is_read && (ph_q == 3'd3)) begin
        case (state_q)
          S_FETCH_A: a_q  <= rd_val;
          S_FETCH_B: b_q  <= rd_val;
          S_FETCH_C: c_q  <= rd_val;
          S_READ_A:  va_q <= rd_val;
          default:   vb_q <= rd_val;
        endcase
      end
      if (go && is_write && (ph_q == 3'd3) && out_addr) out_q <= result;
    end
  end

  assign latch_int = act_q && (is_read || is_write) && (ph_q != 3'd0);
  assign oe_int    = act_q && is_read && (ph_q >= 3'd2);
  assign we_int    = act_q && is_write && (ph_q == 3'd3) && !out_addr;

  // Strobes are forced inactive straight from rst_n so a mid-access reset
  // cannot pass through a low pulse while the state flops clear.
  assign mem_latch  = rst_n && (run ? latch_int : ext_latch);
  assign mem_oe_n   = !(rst_n && run && oe_int);
  assign mem_we_n   = !rst_n || (run ? !we_int : ext_we_n);
  assign bus_oe     = go && ((is_read && (ph_q < 3'd2)) || is_write);
  assign bus_out    = !act_q ? '0 :
                      (is_write && (ph_q >= 3'd2)) ? result : addr;
  assign out_strobe = go && is_write && (ph_q == 3'd3) && out_addr;
  assign out_port   = out_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign state_dbg  = {1'b0, state_q};
endmodule

// File: tb/tb_subneg_core_p.sv
// Bench for subneg_core_p: three cores (BR_MODE 0/1/2) on identical
// behavioural SRAMs, checked against an instruction-level reference model.
module tb_subneg_core_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       run, ext_latch, ext_we_n, step_mode, step;
  logic [7:0] in_port;

  logic [7:0] bus_in [3];
  logic [7:0] bus_out [3];
  logic [7:0] out_port [3];
  logic [7:0] pc [3];
  logic       bus_oe [3];
  logic       mem_latch [3];
  logic       mem_oe_n [3];
  logic       mem_we_n [3];
  logic       out_strobe [3];
  logic       halted [3];
  logic [3:0] state_dbg [3];

  logic [7:0] mem [3][256];
  logic [7:0] lat [3];
  logic       ld_en = 1'b0;
  logic [7:0] ld_a, ld_d;
  logic [7:0] refm [256];

  int tests = 0;
  int fails = 0;
  int we_cnt [3];
  int st_cnt [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      subneg_core_p #(.W(8), .BR_MODE(gi)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ext_latch(ext_latch),
        .ext_we_n(ext_we_n), .step_mode(step_mode), .step(step),
        .in_port(in_port), .bus_in(bus_in[gi]), .bus_out(bus_out[gi]),
        .bus_oe(bus_oe[gi]), .mem_latch(mem_latch[gi]), .mem_oe_n(mem_oe_n[gi]),
        .mem_we_n(mem_we_n[gi]), .out_port(out_port[gi]),
        .out_strobe(out_strobe[gi]), .pc(pc[gi]), .halted(halted[gi]),
        .state_dbg(state_dbg[gi])
      );
      assign bus_in[gi] = mem[gi][lat[gi]];
    end
  endgenerate

  // SRAM: transparent address latch while mem_latch is low, write on the
  // cycle mem_we_n is low, program loading through ld_*.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ld_en) mem[g][ld_a] <= ld_d;
      else if (run && rst_n) begin
        if (!mem_we_n[g]) mem[g][lat[g]] <= bus_out[g];
        if (!mem_latch[g]) lat[g] <= bus_out[g];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    refm[a] = d;
    tick;
    ld_en = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
  endtask

  task automatic start;
    rst_n = 1'b1;
  endtask

  // One instruction at pc=0, computed from the instruction-set rules.
  task automatic model(input int mode, output logic [7:0] res, output logic [7:0] npc,
                       output bit halt, output bit outw);
    logic [7:0] a, b, c, va, vb;
    bit tk;
    a  = refm[0];
    b  = refm[1];
    c  = refm[2];
    va = (a == 8'hFF) ? in_port : refm[a];
    vb = (b == 8'hFF) ? in_port : refm[b];
    res = vb - va;
    case (mode)
      0:       tk = (va > vb);
      1:       tk = ($signed(res) < 0);
      default: tk = ($signed(res) <= 0);
    endcase
    npc  = tk ? c : 8'd3;
    halt = tk && (c == 8'd0);
    outw = (b == 8'hFF);
  endtask

  task automatic run_cycles(input int n, input bit proto);
    logic [7:0] adr [5];
    logic [7:0] r, np;
    bit h, o;
    int p;
    model(0, r, np, h, o);
    adr[0] = 8'd0; adr[1] = 8'd1; adr[2] = 8'd2; adr[3] = refm[0]; adr[4] = refm[1];
    for (int g = 0; g < 3; g++) begin
      we_cnt[g] = 0;
      st_cnt[g] = 0;
    end
    for (int k = 0; k < n; k++) begin
      tick;
      for (int g = 0; g < 3; g++) begin
        if (!mem_we_n[g]) we_cnt[g]++;
        if (out_strobe[g]) st_cnt[g]++;
      end
      if (proto) begin
        if (k < 20) begin
          p = k % 4;
          chk($sformatf("rd%0d/state", k), state_dbg[0], k / 4);
          chk($sformatf("rd%0d/bus_oe", k), bus_oe[0], p < 2);
          chk($sformatf("rd%0d/oe_n", k), mem_oe_n[0], p < 2);
          chk($sformatf("rd%0d/latch", k), mem_latch[0], p != 0);
          chk($sformatf("rd%0d/we_n", k), mem_we_n[0], 1);
          if (p < 2) chk($sformatf("rd%0d/addr", k), bus_out[0], adr[k / 4]);
        end else begin
          p = k - 20;
          chk($sformatf("wr%0d/state", p), state_dbg[0], 5);
          chk($sformatf("wr%0d/bus_oe", p), bus_oe[0], 1);
          chk($sformatf("wr%0d/latch", p), mem_latch[0], p != 0);
          chk($sformatf("wr%0d/we_n", p), mem_we_n[0], p != 3);
          chk($sformatf("wr%0d/oe_n", p), mem_oe_n[0], 1);
          chk($sformatf("wr%0d/data", p), bus_out[0], (p < 2) ? adr[4] : r);
        end
      end
    end
  endtask

  task automatic check_instr(input string tag);
    logic [7:0] r, np, b;
    bit h, o;
    b = refm[1];
    for (int g = 0; g < 3; g++) begin
      model(g, r, np, h, o);
      chk($sformatf("%s/m%0d/pc", tag, g), pc[g], np);
      chk($sformatf("%s/m%0d/halted", tag, g), halted[g], h);
      if (o) begin
        chk($sformatf("%s/m%0d/out_port", tag, g), out_port[g], r);
        chk($sformatf("%s/m%0d/strobes", tag, g), st_cnt[g], 1);
        chk($sformatf("%s/m%0d/we_cycles", tag, g), we_cnt[g], 0);
      end else begin
        chk($sformatf("%s/m%0d/mem", tag, g), mem[g][b], r);
        chk($sformatf("%s/m%0d/we_cycles", tag, g), we_cnt[g], 1);
        chk($sformatf("%s/m%0d/strobes", tag, g), st_cnt[g], 0);
      end
    end
    model(0, r, np, h, o);
    if (!o) refm[b] = r;
    $display("[TB] %s: a=%0d b=%0d c=%0d result=%0d", tag, refm[0], b, refm[2], r);
  endtask

  task automatic load_prog(input logic [7:0] a, b, c, va, vb);
    load(8'd0, a);
    load(8'd1, b);
    load(8'd2, c);
    load(a, va);
    load(b, vb);
  endtask

  initial begin
    logic [7:0] ra, rb, rc;
    run = 1'b0; ext_latch = 1'b1; ext_we_n = 1'b0;
    step_mode = 1'b0; step = 1'b0; in_port = 8'd0;
    rst_n = 1'b0;
    tick;
    tick;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d/pc", g), pc[g], 0);
      chk($sformatf("rst%0d/state", g), state_dbg[g], 0);
      chk($sformatf("rst%0d/latch", g), mem_latch[g], 0);
      chk($sformatf("rst%0d/oe_n", g), mem_oe_n[g], 1);
      chk($sformatf("rst%0d/we_n", g), mem_we_n[g], 1);
      chk($sformatf("rst%0d/bus_oe", g), bus_oe[g], 0);
      chk($sformatf("rst%0d/bus_out", g), bus_out[g], 0);
      chk($sformatf("rst%0d/out_port", g), out_port[g], 0);
      chk($sformatf("rst%0d/strobe", g), out_strobe[g], 0);
      chk($sformatf("rst%0d/halted", g), halted[g], 0);
    end
    run = 1'b1; ext_latch = 1'b0; ext_we_n = 1'b1;
    for (int i = 0; i < 256; i++) load(8'(i), 8'd0);

    // Basic non-branching subtract, with full bus protocol check.
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    start;
    run_cycles(25, 1'b1);
    tick;
    chk("t1/mem11", mem[0][11], 2);
    chk("t1/pc", pc[0], 3);
    check_instr("t1");

    // Borrow case, then zero result (only BR_MODE 2 branches).
    do_reset;
    load_prog(8'd10, 8'd11, 8'd6, 8'd7, 8'd5);
    start; run_cycles(25, 1'b0); tick;
    chk("t2/mem11", mem[0][11], 254);
    chk("t2/pc", pc[0], 6);
    check_instr("t2");
    do_reset;
    load_prog(8'd10, 8'd11, 8'd6, 8'd5, 8'd5);
    start; run_cycles(25, 1'b0); tick;
    chk("t3/pc_mode2", pc[2], 6);
    check_instr("t3");

    // Reads and writes of the I/O address.
    do_reset;
    in_port = 8'd9;
    load(8'd0, 8'hFF); load(8'd1, 8'hFF); load(8'd2, 8'd7);
    start; run_cycles(25, 1'b0); tick;
    check_instr("t4");
    do_reset;
    in_port = 8'd8;
    load(8'd0, 8'd10); load(8'd1, 8'hFF); load(8'd2, 8'd3); load(8'd10, 8'd3);
    start; run_cycles(25, 1'b0); tick;
    chk("t5/out_port", out_port[0], 5);
    chk("t5/strobes", st_cnt[0], 1);
    chk("t5/we_cycles", we_cnt[0], 0);
    check_instr("t5");

    // Branch to itself halts and stays off the bus.
    do_reset;
    load_prog(8'd10, 8'd11, 8'd0, 8'd7, 8'd5);
    start; run_cycles(25, 1'b0); tick;
    chk("t6/halted", halted[0], 1);
    chk("t6/pc", pc[0], 0);
    check_instr("t6");
    repeat (6) tick;
    chk("t6/hold_state", state_dbg[0], 7);
    chk("t6/hold_bus_oe", bus_oe[0], 0);
    chk("t6/hold_we_n", mem_we_n[0], 1);

    // Single-step mode parks in IDLE until a step pulse.
    do_reset;
    step_mode = 1'b1;
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    start; run_cycles(25, 1'b0); tick;
    for (int g = 0; g < 3; g++) chk($sformatf("t7/idle%0d", g), state_dbg[g], 6);
    check_instr("t7");
    repeat (5) tick;
    chk("t7/still_idle", state_dbg[0], 6);
    chk("t7/idle_bus_oe", bus_oe[0], 0);
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("t7/stepped", state_dbg[0], 0);
    chk("t7/fetch_addr", bus_out[0], 3);
    chk("t7/fetch_oe", bus_oe[0], 1);
    step_mode = 1'b0;

    // Freeze during FETCH_B P2 for 7 cycles with external strobes passed through.
    do_reset;
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    start;
    repeat (7) tick;
    run = 1'b0;
    for (int f = 0; f < 7; f++) begin
      ext_latch = 1'($urandom);
      ext_we_n  = 1'($urandom);
      #1;
      chk($sformatf("frz%0d/latch", f), mem_latch[0], ext_latch);
      chk($sformatf("frz%0d/we_n", f), mem_we_n[0], ext_we_n);
      chk($sformatf("frz%0d/oe_n", f), mem_oe_n[0], 1);
      chk($sformatf("frz%0d/bus_oe", f), bus_oe[0], 0);
      chk($sformatf("frz%0d/state", f), state_dbg[0], 1);
      tick;
    end
    run = 1'b1; ext_latch = 1'b0; ext_we_n = 1'b1;
    run_cycles(18, 1'b0);
    chk("frz/pc_before", pc[0], 0);
    tick;
    chk("frz/pc_after", pc[0], 3);
    chk("frz/mem11", mem[0][11], 2);
    refm[11] = 8'd2;

    // Reset asserted in write P3 releases the strobes and restarts at 0.
    do_reset;
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    start;
    repeat (24) tick;
    chk("t9/we_low_p3", mem_we_n[0], 0);
    rst_n = 1'b0;
    #1;
    chk("t9/we_n", mem_we_n[0], 1);
    chk("t9/oe_n", mem_oe_n[0], 1);
    chk("t9/pc", pc[0], 0);
    chk("t9/state", state_dbg[0], 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t9/refetch_addr", bus_out[0], 0);
    chk("t9/refetch_oe", bus_oe[0], 1);
    run_cycles(24, 1'b0);
    tick;
    check_instr("t9");

    // Randomized single instructions.
    for (int t = 0; t < 24; t++) begin
      do_reset;
      in_port = 8'($urandom);
      ra = 8'($urandom_range(3, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(3, 255));
      rc = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      load(8'd0, ra); load(8'd1, rb); load(8'd2, rc);
      load(ra, 8'($urandom));
      load(rb, 8'($urandom));
      start; run_cycles(25, 1'b0); tick;
      check_instr($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/subneg_core_p.md
SUBNEG_CORE_P -- requirements
Module: subneg_core_p

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter W, default 8: width of the data bus, addresses, PC and data words (4..16).
REQ-003 Parameter BR_MODE, default 0: branch rule. 0 = unsigned A>B (borrow); 1 = signed result<0; 2 = signed result<=0.
REQ-004 Port clk  in  1  clock, rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port run  in  1  1 = core owns memory; 0 = core frozen, external pass-through.
REQ-007 Port ext_latch, ext_we_n  in  1 each  external latch/write strobes, used when run=0.
REQ-008 Port step_mode, step  in  1 each  single-step enable and step pulse.
REQ-009 Port in_port  in  W  value returned by reads of address all-ones.
REQ-010 Port bus_in  in  W  data bus input.
REQ-011 Port bus_out, bus_oe  out  W, 1  data bus drive value and drive enable.
REQ-012 Port mem_latch, mem_oe_n, mem_we_n  out  1 each  address latch clock, SRAM output enable, SRAM write enable.
REQ-013 Port out_port, out_strobe  out  W, 1  output register and one-cycle write strobe.
REQ-014 Port pc, halted, state_dbg  out  W, 1, 4  program counter, halt flag, FSM state code.

Function
REQ-015 Each instruction SHALL have states FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, then IDLE or HALT. Bus addresses per state: pc, pc+1, pc+2 (mod 2^W), A, B, B.
REQ-016 A read access SHALL take 4 cycles. P0: bus_out=addr, bus_oe=1, mem_latch=0, mem_oe_n=1, mem_we_n=1. P1: mem_latch=1. P2: bus_oe=0, mem_oe_n=0. P3: capture bus_in. mem_oe_n SHALL return to 1 at the next P0.
REQ-017 A read whose address is all-ones SHALL still run the bus cycle, but SHALL capture in_port at P3 instead of bus_in.
REQ-018 The write access SHALL take 5 cycles with bus_oe=1 throughout. P0: bus_out=B, mem_latch=0. P1: mem_latch=1. P2: bus_out=result. P3: mem_we_n=0. P4: mem_we_n=1.
REQ-019 result SHALL be val_B - val_A mod 2^W.
REQ-020 If addr_B is all-ones, the write SHALL NOT assert mem_we_n. Instead out_port<=result at P3 and out_strobe=1 for that single cycle.
REQ-021 Branch taken per BR_MODE SHALL set next pc=C; otherwise next pc=pc+3 mod 2^W. pc SHALL update at the end of P4.
REQ-022 A taken branch with C equal to the current pc SHALL enter HALT after P4. In HALT: halted=1, bus_oe=0, all strobes inactive, state held until reset.
REQ-023 With step_mode=1, after P4 the FSM SHALL enter IDLE. It SHALL leave IDLE to FETCH_A on the first cycle step=1. With step_mode=0, IDLE SHALL be skipped.
REQ-024 With run=0, the FSM, pc and registers SHALL hold. mem_latch=ext_latch, mem_we_n=ext_we_n, mem_oe_n=1, bus_oe=0, out_strobe=0. The access SHALL resume at the held phase when run returns to 1.
REQ-025 An instruction SHALL take 25 cycles (5x4 + 5) with run=1 and step_mode=0.
REQ-026 state_dbg SHALL encode the states in order: FETCH_A=0, FETCH_B=1, FETCH_C=2, READ_A=3, READ_B=4, WRITE=5, IDLE=6, HALT=7.

Reset
REQ-027 While rst_n=0, outputs SHALL immediately take these values: pc=0, state FETCH_A P0, mem_latch=0, mem_oe_n=1, mem_we_n=1, bus_oe=0, bus_out=0, out_port=0, out_strobe=0, halted=0.
REQ-028 Reset asserted mid-access SHALL deassert mem_we_n and mem_oe_n asynchronously, with no glitch low.
REQ-029 After rst_n rises, the first fetch SHALL begin on the next clock edge.

Verification (W=8, behavioural SRAM)
REQ-030 mem[0..2]={10,11,6}, mem[10]=3, mem[11]=5, BR_MODE=0 -> after 25 cycles mem[11]=2, pc=3, exactly one mem_we_n low cycle.
REQ-031 Same program with mem[10]=7 -> mem[11]=254 and pc=6. With BR_MODE=2 and mem[10]=5 -> result 0, pc=6.
REQ-032 Instruction {255,255,...} with in_port=9 -> val_A=val_B=9. Instruction {10,255,3} with mem[10]=3 and val_B read as in_port=8 -> out_port=5, out_strobe high exactly 1 cycle, mem_we_n never low.
REQ-033 Instruction at pc=0 is {10,11,0} with mem[10]=7, mem[11]=5 -> halted=1 at cycle 25, bus_oe=0 thereafter, pc=0.
REQ-034 step_mode=1 -> FSM waits in IDLE (state_dbg=6) until a step pulse, then fetches. Dropping run mid-read -> outputs follow ext_latch/ext_we_n, and completion is delayed by exactly the frozen cycles.
REQ-035 rst_n low during write P3 -> mem_we_n=1 before the next clock edge, pc=0, and a refetch from address 0 follows.
